// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: oversamples rxd on rising edges of baud16 and emits each byte with a valid strobe.
// Optional even-parity frames are built in when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk50,
  input  logic                 rst_n,
  input  logic                 baud16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Reset asserts asynchronously but releases on a clk50 edge.
  logic [1:0] rst_sync;
  logic       rst_ni;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_ni = rst_sync[1];

  // Input conditioning: rxd synchroniser plus edge history, baud16 synchroniser plus history
  logic rxd_p0, rxd_p1, rxd_p2;
  logic baud_p0, baud_p1, baud_p2;
  logic rxd_s, rxd_fall, tick;

  always_ff @(posedge clk50 or negedge rst_ni) begin
    if (!rst_ni) begin
      rxd_p0  <= 1'b1;
      rxd_p1  <= 1'b1;
      rxd_p2  <= 1'b1;
      baud_p0 <= 1'b0;
      baud_p1 <= 1'b0;
      baud_p2 <= 1'b0;
    end else begin
      rxd_p0  <= rxd;
      rxd_p1  <= rxd_p0;
      rxd_p2  <= rxd_p1;
      baud_p0 <= baud16;
      baud_p1 <= baud_p0;
      baud_p2 <= baud_p1;
    end
  end

  assign rxd_s    = rxd_p1;
  assign rxd_fall = rxd_p2 & ~rxd_p1;
  assign tick     = baud_p1 & ~baud_p2;

  // Frame FSM
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 vld_n, ferr_n, perr_n;
`ifdef UART_RX_PARITY_EN
  logic                 pbad, pbad_n;
`endif

  always_ff @(posedge clk50 or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      rx_data    <= data_n;
      rx_valid   <= vld_n;
      frame_err  <= ferr_n;
`ifdef UART_RX_PARITY_EN
      pbad       <= pbad_n;
      parity_err <= perr_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = rx_data;
    vld_n   = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_n  = pbad;
`endif
    unique case (state)
      ST_IDLE: begin
        if (rxd_fall) begin
          state_n = ST_START;
          cnt_n   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (cnt == CNT_HALF) begin
            cnt_n = '0;
            if (!rxd_s) begin
              state_n = ST_DATA;
              idx_n   = '0;
`ifdef UART_RX_PARITY_EN
              pbad_n  = 1'b0;
`endif
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            pbad_n  = ^{shreg, rxd_s};
            state_n = ST_STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (rxd_s) begin
              state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (pbad) begin
                perr_n = 1'b1;
              end else begin
                vld_n  = 1'b1;
                data_n = shreg;
              end
`else
              vld_n  = 1'b1;
              data_n = shreg;
`endif
            end else begin
              ferr_n  = 1'b1;
              state_n = ST_BREAK;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (rxd_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx; a fast divider model (20 clk50 cycles per baud16 period) keeps frames short.
module tb_uart_rx;
  localparam int DIV = 20;
  localparam int BIT = DIV * 16;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud16 = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  int checks = 0;
  int errors = 0;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk50(clk50), .rst_n(rst_n), .baud16(baud16), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #10 clk50 = ~clk50;

  int dcnt = 0;
  int cyc = 0;
  always @(posedge clk50) begin
    dcnt   <= (dcnt == DIV - 1) ? 0 : dcnt + 1;
    baud16 <= (dcnt < DIV / 2);
    cyc    <= cyc + 1;
  end

  int         nvalid = 0;
  int         nferr = 0;
  int         nperr = 0;
  logic [7:0] vlog [32];
  int         vtime [32];
  logic       vbusy [32];

  always @(negedge clk50) begin
    if (rx_valid && nvalid < 32) begin
      vlog[nvalid]  <= rx_data;
      vtime[nvalid] <= cyc;
      vbusy[nvalid] <= busy;
    end
    if (rx_valid)   nvalid <= nvalid + 1;
    if (frame_err)  nferr  <= nferr + 1;
    if (parity_err) nperr  <= nperr + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    idle(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d ^ par_flip);
`else
    if (par_flip) rxd = 1'b1;
`endif
    send_bit(stop_v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    idle(BIT);
  endtask

  task automatic test_single();
    int b = nvalid;
    int f = nferr;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(BIT);
    checks++; if (nvalid - b != 1)     begin errors++; $display("FAIL single_count got %0d want 1", nvalid - b); end
    checks++; if (vlog[b] !== 8'h55)   begin errors++; $display("FAIL single_data got %h want 55", vlog[b]); end
    checks++; if (nferr - f != 0)      begin errors++; $display("FAIL single_ferr got %0d want 0", nferr - f); end
    checks++; if (vbusy[b] !== 1'b0)   begin errors++; $display("FAIL single_busy_at_valid got %b want 0", vbusy[b]); end
  endtask

  task automatic test_back_to_back();
    int b = nvalid;
    int gap;
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(BIT);
    checks++; if (nvalid - b != 2)      begin errors++; $display("FAIL b2b_count got %0d want 2", nvalid - b); end
    checks++; if (vlog[b] !== 8'hA3)    begin errors++; $display("FAIL b2b_first got %h want a3", vlog[b]); end
    checks++; if (vlog[b+1] !== 8'h0F)  begin errors++; $display("FAIL b2b_second got %h want 0f", vlog[b+1]); end
    gap = vtime[b+1] - vtime[b];
    checks++; if (gap < 10*BIT - 2*DIV || gap > 10*BIT + 2*DIV)
      begin errors++; $display("FAIL b2b_gap got %0d want about %0d", gap, 10*BIT); end
  endtask

  task automatic test_glitch();
    int b = nvalid;
    int f = nferr;
    rxd = 1'b0;
    idle(100);
    rxd = 1'b1;
    idle(2*BIT);
    checks++; if (nvalid - b != 0) begin errors++; $display("FAIL glitch_valid got %0d want 0", nvalid - b); end
    checks++; if (nferr - f != 0)  begin errors++; $display("FAIL glitch_ferr got %0d want 0", nferr - f); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL glitch_busy got %b want 0", busy); end
  endtask

  task automatic test_frame_err();
    int b = nvalid;
    int f = nferr;
    logic [7:0] prev = rx_data;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(3*BIT);
    checks++; if (nferr - f != 1)   begin errors++; $display("FAIL ferr_count got %0d want 1", nferr - f); end
    checks++; if (nvalid - b != 0)  begin errors++; $display("FAIL ferr_valid got %0d want 0", nvalid - b); end
    checks++; if (rx_data !== prev) begin errors++; $display("FAIL ferr_data_held got %h want %h", rx_data, prev); end
    checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL ferr_busy_break got %b want 1", busy); end
    rxd = 1'b1;
    idle(BIT);
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL ferr_busy_release got %b want 0", busy); end
    checks++; if (nferr - f != 1)   begin errors++; $display("FAIL ferr_count_after got %0d want 1", nferr - f); end
  endtask

  task automatic test_reset_mid();
    int b = nvalid;
    int f = nferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rxd = 1'b1;
    idle(BIT/2);
    rst_n = 1'b0;
    idle(2);
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", rx_data); end
    rst_n = 1'b1;
    idle(BIT);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(BIT);
    checks++; if (nvalid - b != 1)   begin errors++; $display("FAIL rstmid_count got %0d want 1", nvalid - b); end
    checks++; if (vlog[b] !== 8'h81) begin errors++; $display("FAIL rstmid_data_after got %h want 81", vlog[b]); end
    checks++; if (nferr - f != 0)    begin errors++; $display("FAIL rstmid_ferr got %0d want 0", nferr - f); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int b = nvalid;
    int p = nperr;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(BIT);
    checks++; if (nvalid - b != 1)   begin errors++; $display("FAIL par_good_count got %0d want 1", nvalid - b); end
    checks++; if (vlog[b] !== 8'h07) begin errors++; $display("FAIL par_good_data got %h want 07", vlog[b]); end
    checks++; if (nperr - p != 0)    begin errors++; $display("FAIL par_good_perr got %0d want 0", nperr - p); end
    send_frame(8'h07, 1'b1, 1'b1);
    idle(BIT);
    checks++; if (nperr - p != 1)    begin errors++; $display("FAIL par_bad_perr got %0d want 1", nperr - p); end
    checks++; if (nvalid - b != 1)   begin errors++; $display("FAIL par_bad_valid got %0d want 1", nvalid - b); end
    checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_bad_data got %h want 07", rx_data); end
`else
    checks++; if (nperr != 0)        begin errors++; $display("FAIL noparity_perr got %0d want 0", nperr); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL noparity_level got %b want 0", parity_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
